// File: rtl/cfg_chain_driver.sv
// cfg_chain_driver
// Host-side transmitter for the serial configuration shift chain of the
// analog switch matrix. A full configuration word is taken over a
// valid/ready handshake and shifted MSB-first onto the chain. While it
// shifts, the old chain contents come back on cfg_readback. They are
// collected into rd_data and compared against the word written before.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          asynchronous active-high reset
//   wr_data      configuration word, bit CHAIN_LEN-1 shifted first
//   wr_valid     word offered
//   wr_ready     driver can accept a word
//   cfg_data     serial data to the chain
//   cfg_enable   chain shift enable
//   cfg_readback serial output of the chain
//   rd_data      previous chain contents, first sampled bit at MSB
//   rd_valid     one-cycle pulse, rd_data/rd_mismatch valid
//   rd_mismatch  with rd_valid: rd_data differs from the previous written word
//   busy         driver is not idle
module cfg_chain_driver #(
  parameter int CHAIN_LEN = 192,
  parameter int RB_LAT    = 1,
  parameter int GAP       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHAIN_LEN-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic                 cfg_data,
  output logic                 cfg_enable,
  input  logic                 cfg_readback,
  output logic [CHAIN_LEN-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 rd_mismatch,
  output logic                 busy
);

  localparam int KW        = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
  localparam int CNT_MAX   = (RB_LAT > GAP) ? RB_LAT : GAP;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int TAIL_LOAD = (RB_LAT > 0) ? RB_LAT - 1 : 0;
  localparam int GAP_LOAD  = GAP - 1;

  localparam logic [KW-1:0] K_LAST   = KW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] TAIL_CNT = CW'(TAIL_LOAD);
  localparam logic [CW-1:0] GAP_CNT  = CW'(GAP_LOAD);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_TAIL  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] word_q, word_d;
  logic [CHAIN_LEN-1:0] shift_q, shift_d;
  logic                 wr_ready_q, wr_ready_d;
  logic                 cfg_data_q, cfg_data_d;
  logic                 cfg_enable_q, cfg_enable_d;
  logic                 busy_q, busy_d;

  logic [KW-1:0]        s_q, s_d;
  logic [CHAIN_LEN-1:0] rb_sr_q, rb_sr_d;
  logic [CHAIN_LEN-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_mismatch_q, rd_mismatch_d;
  logic [CHAIN_LEN-1:0] prev_word_q, prev_word_d;
  logic                 prev_valid_q, prev_valid_d;
  logic                 strobe;

  assign wr_ready    = wr_ready_q;
  assign cfg_data    = cfg_data_q;
  assign cfg_enable  = cfg_enable_q;
  assign busy        = busy_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_mismatch = rd_mismatch_q;

  // Transfer sequencer. The outputs are registered, so each branch computes
  // what the chain should see in the following cycle: the handshake already
  // loads the MSB so shifting starts in the very next cycle. shift_q holds the
  // bits still to be sent, left-aligned. word_q keeps the whole word for the
  // later readback comparison.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    shift_d      = shift_q;
    wr_ready_d   = wr_ready_q;
    cfg_data_d   = cfg_data_q;
    cfg_enable_d = cfg_enable_q;
    busy_d       = busy_q;
    case (state_q)
      S_IDLE: begin
        wr_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (wr_valid && wr_ready_q) begin
          state_d      = S_SHIFT;
          word_d       = wr_data;
          shift_d      = {wr_data[CHAIN_LEN-2:0], 1'b0};
          k_d          = '0;
          cfg_enable_d = 1'b1;
          cfg_data_d   = wr_data[CHAIN_LEN-1];
          wr_ready_d   = 1'b0;
          busy_d       = 1'b1;
        end
      end
      S_SHIFT: begin
        if (k_q == K_LAST) begin
          cfg_enable_d = 1'b0;
          cfg_data_d   = 1'b0;
          if (RB_LAT > 0) begin
            state_d = S_TAIL;
            cnt_d   = TAIL_CNT;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_CNT;
          end
        end else begin
          k_d        = k_q + 1'b1;
          cfg_data_d = shift_q[CHAIN_LEN-1];
          shift_d    = {shift_q[CHAIN_LEN-2:0], 1'b0};
        end
      end
      S_TAIL: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_CNT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d    = S_IDLE;
          wr_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // Sequencer state. Reset drops cfg_enable immediately, which aborts any
  // transfer in flight and leaves the chain partly shifted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      shift_q      <= '0;
      wr_ready_q   <= 1'b0;
      cfg_data_q   <= 1'b0;
      cfg_enable_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      shift_q      <= shift_d;
      wr_ready_q   <= wr_ready_d;
      cfg_data_q   <= cfg_data_d;
      cfg_enable_q <= cfg_enable_d;
      busy_q       <= busy_d;
    end
  end

  // The chain output lags the driven bit by RB_LAT cycles, so the enable is
  // delayed by the same amount to mark the cycles where cfg_readback holds
  // an old chain bit.
  generate
    if (RB_LAT == 0) begin : g_no_dly
      assign strobe = cfg_enable_q;
    end else begin : g_dly
      logic [RB_LAT-1:0] en_dly_q, en_dly_d;

      always_comb begin
        en_dly_d    = en_dly_q << 1;
        en_dly_d[0] = cfg_enable_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) en_dly_q <= '0;
        else     en_dly_q <= en_dly_d;
      end

      assign strobe = en_dly_q[RB_LAT-1];
    end
  endgenerate

  // Readback capture. The first sampled bit ends up at the MSB. When the
  // last bit arrives, the completed word is published together with its
  // comparison against the word from the previous transfer. Then the current
  // word becomes the reference for the next transfer. word_q is still stable
  // here because the gap keeps the sequencer from accepting a new word yet.
  always_comb begin
    s_d           = s_q;
    rb_sr_d       = rb_sr_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    rd_mismatch_d = rd_mismatch_q;
    prev_word_d   = prev_word_q;
    prev_valid_d  = prev_valid_q;
    if (strobe) begin
      rb_sr_d = {rb_sr_q[CHAIN_LEN-2:0], cfg_readback};
      if (s_q == K_LAST) begin
        s_d           = '0;
        rd_data_d     = rb_sr_d;
        rd_valid_d    = 1'b1;
        rd_mismatch_d = prev_valid_q && (rb_sr_d != prev_word_q);
        prev_word_d   = word_q;
        prev_valid_d  = 1'b1;
      end else begin
        s_d = s_q + 1'b1;
      end
    end
  end

  // Readback state. Clearing prev_valid on reset means the first report
  // after a reset never flags a mismatch, whatever the chain holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q           <= '0;
      rb_sr_q       <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_mismatch_q <= 1'b0;
      prev_word_q   <= '0;
      prev_valid_q  <= 1'b0;
    end else begin
      s_q           <= s_d;
      rb_sr_q       <= rb_sr_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_mismatch_q <= rd_mismatch_d;
      prev_word_q   <= prev_word_d;
      prev_valid_q  <= prev_valid_d;
    end
  end

endmodule

// File: tb/tb_cfg_chain_driver.sv
// Testbench for cfg_chain_driver. Instance A is a short chain (8 bits,
// readback latency 1) with a behavioural chain that can model a stuck bit.
// Instance B is a full 192-bit chain with no readback latency.
module tb_cfg_chain_driver;

  localparam int LA = 8;
  localparam int RA = 1;
  localparam int GA = 2;
  localparam int LB = 192;
  localparam int RB = 0;
  localparam int GB = 2;
  localparam int STUCK_POS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [LA-1:0] wr_data_a = '0;
  logic          wr_valid_a = 1'b0;
  logic          wr_ready_a, cfg_data_a, cfg_enable_a, cfg_readback_a;
  logic [LA-1:0] rd_data_a;
  logic          rd_valid_a, rd_mismatch_a, busy_a;

  logic [LB-1:0] wr_data_b = '0;
  logic          wr_valid_b = 1'b0;
  logic          wr_ready_b, cfg_data_b, cfg_enable_b, cfg_readback_b;
  logic [LB-1:0] rd_data_b;
  logic          rd_valid_b, rd_mismatch_b, busy_b;

  int checks = 0;
  int errors = 0;

  // Behavioural chain models: each is a plain shift register that moves one
  // place per enabled clock.
  logic [LA-1:0] chain_a = '0;
  logic [LB-1:0] chain_b = '0;
  logic          rbd_a = 1'b0;
  int            n_a = 0;
  logic          stuck_en = 1'b0;

  // Reference model for instance A: each accepted word returns the chain
  // contents as they were when it was accepted. It flags a mismatch when
  // those differ from the last word whose report completed since reset.
  logic [LA-1:0] pend_old[$];
  logic [LA-1:0] pend_word[$];
  logic [LA-1:0] last_word = '0;
  logic          have_prev = 1'b0;
  logic [LA-1:0] last_rd_data_a = '0;
  logic          last_rd_mm_a = 1'b0;

  int            rdb_cnt = 0;
  logic [LB-1:0] rdb_data = '0;
  logic          rdb_mm = 1'b0;

  cfg_chain_driver #(.CHAIN_LEN(LA), .RB_LAT(RA), .GAP(GA)) dut_a (
    .clk(clk), .rst(rst), .wr_data(wr_data_a), .wr_valid(wr_valid_a),
    .wr_ready(wr_ready_a), .cfg_data(cfg_data_a), .cfg_enable(cfg_enable_a),
    .cfg_readback(cfg_readback_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .rd_mismatch(rd_mismatch_a), .busy(busy_a)
  );

  cfg_chain_driver #(.CHAIN_LEN(LB), .RB_LAT(RB), .GAP(GB)) dut_b (
    .clk(clk), .rst(rst), .wr_data(wr_data_b), .wr_valid(wr_valid_b),
    .wr_ready(wr_ready_b), .cfg_data(cfg_data_b), .cfg_enable(cfg_enable_b),
    .cfg_readback(cfg_readback_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .rd_mismatch(rd_mismatch_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  assign cfg_readback_a = rbd_a;
  assign cfg_readback_b = chain_b[LB-1];

  task automatic checkOutput(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Chain A. The bit stored at STUCK_POS reads back as 1 when stuck_en is set.
  // n_a counts the shifts in the current burst, so chain_a[LA-1] holds
  // original position LA-1-n_a. The output then passes one register of latency.
  always @(posedge clk) begin
    rbd_a <= chain_a[LA-1] | (stuck_en && (n_a == LA - 1 - STUCK_POS));
    if (cfg_enable_a) begin
      chain_a <= {chain_a[LA-2:0], cfg_data_a};
      n_a     <= n_a + 1;
    end else begin
      n_a <= 0;
    end
  end

  // Chain B, no stuck bits and a combinational readback.
  always @(posedge clk) begin
    if (cfg_enable_b) chain_b <= {chain_b[LB-2:0], cfg_data_b};
  end

  // Record every accepted word for A together with the chain contents it
  // should read back.
  always @(posedge clk) begin
    if (!rst && wr_valid_a && wr_ready_a) begin
      pend_old.push_back(chain_a | (stuck_en ? LA'(1 << STUCK_POS) : LA'(0)));
      pend_word.push_back(wr_data_a);
    end
  end

  // A reset discards everything in flight and forgets the last written word.
  always @(posedge rst) begin
    pend_old.delete();
    pend_word.delete();
    have_prev = 1'b0;
  end

  // Compare every readback report from A with the reference model.
  always @(negedge clk) begin
    if (rd_valid_a) begin
      if (pend_old.size() == 0) begin
        checkOutput("rd_valid_unexpected", rd_valid_a, 1'b0);
      end else begin
        logic [LA-1:0] old_w, new_w;
        logic          exp_mm;
        old_w  = pend_old.pop_front();
        new_w  = pend_word.pop_front();
        exp_mm = have_prev && (old_w != last_word);
        checkOutput("rd_data_a", rd_data_a, old_w);
        checkOutput("rd_mismatch_a", rd_mismatch_a, exp_mm);
        last_word      = new_w;
        have_prev      = 1'b1;
        last_rd_data_a = rd_data_a;
        last_rd_mm_a   = rd_mismatch_a;
      end
    end
  end

  // Capture the reports from B.
  always @(negedge clk) begin
    if (rd_valid_b) begin
      rdb_cnt++;
      rdb_data = rd_data_b;
      rdb_mm   = rd_mismatch_b;
    end
  end

  // Offer a word to A and wait for the handshake. Returns at the falling
  // edge of the first shift cycle.
  task automatic applyStimulus(input logic [LA-1:0] word);
    int waited = 0;
    wr_data_a  = word;
    wr_valid_a = 1'b1;
    while (!wr_ready_a && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("hs_timeout", waited < 50, 1'b1);
    @(negedge clk);
    wr_valid_a = 1'b0;
  endtask

  task automatic waitIdle();
    int w = 0;
    while (!wr_ready_a && w < 100) begin
      @(negedge clk);
      w++;
    end
    checkOutput("idle_timeout", w < 100, 1'b1);
  endtask

  // Perform a full transfer on A and check the serial stream, the burst
  // length and the time until the driver is ready again.
  task automatic runTransfer(input logic [LA-1:0] word);
    int cycles;
    applyStimulus(word);
    for (int i = 0; i < LA; i++) begin
      checkOutput("cfg_enable_a", cfg_enable_a, 1'b1);
      checkOutput("cfg_data_a", cfg_data_a, word[LA-1-i]);
      @(negedge clk);
    end
    checkOutput("enable_end_a", cfg_enable_a, 1'b0);
    cycles = LA + 1;
    while (!wr_ready_a && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("ready_latency_a", cycles, LA + RA + GA + 1);
    checkOutput("rd_pending_a", pend_old.size(), 0);
    checkOutput("chain_a", chain_a, word);
  endtask

  initial begin
    logic [LB-1:0] word_b;
    int low_cnt, waited, en_cnt;
    logic prev_en, seen_end;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_wr_ready", wr_ready_a, 1'b0);
    checkOutput("rst_cfg_data", cfg_data_a, 1'b0);
    checkOutput("rst_cfg_enable", cfg_enable_a, 1'b0);
    checkOutput("rst_rd_data", rd_data_a, '0);
    checkOutput("rst_rd_valid", rd_valid_a, 1'b0);
    checkOutput("rst_rd_mismatch", rd_mismatch_a, 1'b0);
    checkOutput("rst_busy", busy_a, 1'b0);
    checkOutput("rst_cfg_enable_b", cfg_enable_b, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst_a", wr_ready_a, 1'b1);
    checkOutput("ready_after_rst_b", wr_ready_b, 1'b1);

    $display("[TB] write 0xA5 then 0x3C");
    runTransfer(8'hA5);
    checkOutput("first_rd_data", last_rd_data_a, 8'h00);
    runTransfer(8'h3C);
    checkOutput("second_rd_data", last_rd_data_a, 8'hA5);

    $display("[TB] stuck chain bit");
    stuck_en = 1'b1;
    runTransfer(8'h00);
    runTransfer(8'h00);
    checkOutput("stuck_rd_data", last_rd_data_a, 8'h04);
    checkOutput("stuck_rd_mm", last_rd_mm_a, 1'b1);
    stuck_en = 1'b0;

    $display("[TB] continuous valid with random data");
    low_cnt  = 0;
    prev_en  = 1'b0;
    seen_end = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (cfg_enable_a && !prev_en && seen_end) checkOutput("gap_len", low_cnt, RA + GA);
      if (!cfg_enable_a && prev_en) begin
        seen_end = 1'b1;
        low_cnt  = 0;
      end
      if (busy_a && !cfg_enable_a) low_cnt++;
      prev_en    = cfg_enable_a;
      wr_data_a  = LA'($urandom);
      wr_valid_a = 1'b1;
      @(negedge clk);
    end
    wr_valid_a = 1'b0;
    waitIdle();
    checkOutput("burst_pending", pend_old.size(), 0);
    checkOutput("burst_chain", chain_a, last_word);

    $display("[TB] reset during shift");
    applyStimulus(LA'($urandom));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_enable", cfg_enable_a, 1'b0);
    checkOutput("abort_busy", busy_a, 1'b0);
    checkOutput("abort_ready", wr_ready_a, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_abort", wr_ready_a, 1'b1);
    runTransfer(LA'($urandom));
    checkOutput("post_abort_mm", last_rd_mm_a, 1'b0);

    $display("[TB] long chain");
    for (int i = 0; i < LB / 32; i++) word_b[i*32 +: 32] = $urandom;
    for (int t = 0; t < 2; t++) begin
      wr_data_b  = word_b;
      wr_valid_b = 1'b1;
      waited     = 0;
      while (!wr_ready_b && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("b_hs_timeout", waited < 50, 1'b1);
      @(negedge clk);
      wr_valid_b = 1'b0;
      en_cnt = 0;
      waited = 0;
      while (!wr_ready_b && waited < 400) begin
        if (cfg_enable_b) en_cnt++;
        @(negedge clk);
        waited++;
      end
      checkOutput("b_enables", en_cnt, LB);
      checkOutput("b_latency", waited + 1, LB + RB + GB + 1);
      checkOutput("b_rd_count", rdb_cnt, t + 1);
      checkOutput("b_rd_data", rdb_data, (t == 0) ? '0 : word_b);
      checkOutput("b_rd_mm", rdb_mm, 1'b0);
    end
    checkOutput("b_chain", chain_b, word_b);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
